riscv_lsu: RTL and testbench

- Load/store unit between the MEM pipeline stage and the data cache (riscv_cache_d). Directly upstream of the cache; it feeds the cache's write-enable, write-kind, address and store data, and consumes its read data.
- Handles byte and halfword lane placement, load sign and zero extension, and misalignment detection.
- The cache's SB and SH write modes only update the low lanes of a word. Sub-word stores at a non-zero byte offset are therefore executed as read-modify-write (RMW) sequences that end in a full-word SW.
- One request is in flight at a time, using a valid/ready request handshake and a single-cycle response pulse.

---
 rtl/riscv_lsu.sv | 197 +++++++++++++++++++
 tb/tb_riscv_lsu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// Load/store unit between the MEM stage and the data cache: lane placement, load extension,
// misalignment rejection and read-modify-write for sub-word stores at non-zero offsets.
`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`define CACHE_D_WRITE_SB 2'b00
`define CACHE_D_WRITE_SH 2'b01
`define CACHE_D_WRITE_SW 2'b10
`endif

module riscv_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_is_store,
  input  logic [1:0]                    req_size,
  input  logic                          req_unsigned,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          resp_valid,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic                          resp_misaligned,
  output logic                          cache_d_write_en,
  output logic [`CACHE_D_WRITE_LEN-1:0] cache_d_write,
  output logic [ADDR_W-1:0]             cache_addr,
  output logic [DATA_W-1:0]             cache_data_to_cache,
  input  logic [DATA_W-1:0]             cache_data_out
);

  typedef enum logic [2:0] {StIdle, StRd, StRdData, StWr1, StWr2, StResp} state_e;

  state_e                          state_q, state_d;
  logic [1:0]                      size_q, size_d;
  logic                            uns_q, uns_d;
  logic                            rmw_q, rmw_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [DATA_W-1:0]               wdata_q, wdata_d;
  logic [DATA_W-1:0]               rdata_q, rdata_d;
  logic                            mis_q, mis_d;
  logic [ADDR_W-1:0]               caddr_q, caddr_d;
  logic [DATA_W-1:0]               cdata_q, cdata_d;
  logic [`CACHE_D_WRITE_LEN-1:0]   ckind_q, ckind_d;

  logic                            req_mis;
  logic [7:0]                      ld_byte;
  logic [15:0]                     ld_half;
  logic [DATA_W-1:0]               ld_ext;
  logic [DATA_W-1:0]               merged;

  always_comb begin
    unique case (req_size)
      2'b00:   req_mis = 1'b0;
      2'b01:   req_mis = req_addr[0];
      2'b10:   req_mis = (req_addr[1:0] != 2'b00);
      default: req_mis = 1'b1;
    endcase
  end

  // Lane extraction and extension of the word returned by the cache.
  always_comb begin
    unique case (addr_q[1:0])
      2'b00:   ld_byte = cache_data_out[7:0];
      2'b01:   ld_byte = cache_data_out[15:8];
      2'b10:   ld_byte = cache_data_out[23:16];
      default: ld_byte = cache_data_out[31:24];
    endcase
    ld_half = addr_q[1] ? cache_data_out[31:16] : cache_data_out[15:0];
    unique case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = cache_data_out;
    endcase
  end

  // Merge the store lane(s) into the read word for the full-word write-back.
  always_comb begin
    merged = cache_data_out;
    if (size_q == 2'b00) begin
      unique case (addr_q[1:0])
        2'b00:   merged[7:0]   = wdata_q[7:0];
        2'b01:   merged[15:8]  = wdata_q[7:0];
        2'b10:   merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rmw_d   = rmw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    caddr_d = caddr_q;
    cdata_d = cdata_q;
    ckind_d = ckind_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rmw_d   = 1'b0;
          mis_d   = req_mis;
          if (req_mis) begin
            rdata_d = '0;
            state_d = StResp;
          end else begin
            caddr_d = {req_addr[ADDR_W-1:2], 2'b00};
            if (!req_is_store) begin
              state_d = StRd;
            end else if (req_size == 2'b10 || req_addr[1:0] == 2'b00) begin
              cdata_d = req_wdata;
              unique case (req_size)
                2'b00:   ckind_d = `CACHE_D_WRITE_SB;
                2'b01:   ckind_d = `CACHE_D_WRITE_SH;
                default: ckind_d = `CACHE_D_WRITE_SW;
              endcase
              state_d = StWr1;
            end else begin
              rmw_d   = 1'b1;
              state_d = StRd;
            end
          end
        end
      end
      StRd: state_d = StRdData;
      StRdData: begin
        if (rmw_q) begin
          cdata_d = merged;
          ckind_d = `CACHE_D_WRITE_SW;
          state_d = StWr1;
        end else begin
          rdata_d = ld_ext;
          state_d = StResp;
        end
      end
      StWr1: state_d = StWr2;
      StWr2: begin
        rdata_d = '0;
        state_d = StResp;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rmw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      caddr_q <= '0;
      cdata_q <= '0;
      ckind_q <= `CACHE_D_WRITE_SW;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rmw_q   <= rmw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
      ckind_q <= ckind_d;
    end
  end

  assign req_ready           = (state_q == StIdle);
  assign resp_valid          = (state_q == StResp);
  assign resp_rdata          = rdata_q;
  assign resp_misaligned     = mis_q;
  assign cache_d_write_en    = (state_q == StWr1);
  assign cache_d_write       = ckind_q;
  assign cache_addr          = caddr_q;
  assign cache_data_to_cache = cdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu with a behavioural data-cache model.
`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`define CACHE_D_WRITE_SB 2'b00
`define CACHE_D_WRITE_SH 2'b01
`define CACHE_D_WRITE_SW 2'b10
`endif

module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        cache_d_write_en;
  logic [`CACHE_D_WRITE_LEN-1:0] cache_d_write;
  logic [31:0] cache_addr;
  logic [31:0] cache_data_to_cache;
  logic [31:0] cache_data_out = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  localparam logic [1:0] SB = `CACHE_D_WRITE_SB;
  localparam logic [1:0] SH = `CACHE_D_WRITE_SH;
  localparam logic [1:0] SW = `CACHE_D_WRITE_SW;

  riscv_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_is_store        (req_is_store),
    .req_size            (req_size),
    .req_unsigned        (req_unsigned),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .resp_valid          (resp_valid),
    .resp_rdata          (resp_rdata),
    .resp_misaligned     (resp_misaligned),
    .cache_d_write_en    (cache_d_write_en),
    .cache_d_write       (cache_d_write),
    .cache_addr          (cache_addr),
    .cache_data_to_cache (cache_data_to_cache),
    .cache_data_out      (cache_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cache model: registered read, write enable/kind registered, RAM written one cycle later.
  logic [31:0] mem [0:63];
  logic        we_q = 1'b0;
  logic [1:0]  wk_q = 2'b10;
  initial for (int i = 0; i < 64; i++) mem[i] = '0;
  always @(posedge clk) begin
    cache_data_out <= mem[cache_addr[7:2]];
    we_q <= cache_d_write_en;
    wk_q <= cache_d_write;
    if (we_q) begin
      if (wk_q == SB)      mem[cache_addr[7:2]][7:0]  <= cache_data_to_cache[7:0];
      else if (wk_q == SH) mem[cache_addr[7:2]][15:0] <= cache_data_to_cache[15:0];
      else                 mem[cache_addr[7:2]]       <= cache_data_to_cache;
    end
  end

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          we;
    logic [1:0]  wk;
    logic [31:0] wd;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          we_cnt = 0;
  logic [1:0]  seen_wk = '0;
  logic [31:0] seen_wd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses resp_valid.
  always @(negedge clk) begin
    if (rst) begin
      we_cnt = 0;
    end else begin
      if (cache_d_write_en) begin
        we_cnt++;
        seen_wk = cache_d_write;
        seen_wd = cache_data_to_cache;
      end
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_resp: got resp_valid=1 want 0");
        end else begin
          e = sbq.pop_front();
          chk({e.nm, "_mis"}, {31'd0, resp_misaligned}, {31'd0, e.mis});
          if (!e.mis) chk({e.nm, "_rdata"}, resp_rdata, e.rd);
          chk({e.nm, "_lat"}, cyc - e.acc, e.lat);
          chk({e.nm, "_we_cnt"}, we_cnt, e.we);
          if (e.we > 0) begin
            chk({e.nm, "_wkind"}, {30'd0, seen_wk}, {30'd0, e.wk});
            chk({e.nm, "_wdata"}, seen_wd, e.wd);
          end
        end
        we_cnt = 0;
      end
    end
  end

  task automatic issue(input string nm, input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] erd,
                       input logic emis, input int elat, input int ewe, input logic [1:0] ewk,
                       input logic [31:0] ewd);
    exp_t x;
    int   guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL %s_ready: got req_ready=0 want 1", nm);
    end
    req_is_store = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    x.nm = nm; x.rd = erd; x.mis = emis; x.lat = elat;
    x.we = ewe; x.wk = ewk; x.wd = ewd; x.acc = cyc;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hxxxx_xxxx;
    req_wdata = 32'hxxxx_xxxx;
    guard = 0;
    while (sbq.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no resp want resp", nm);
      sbq.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({nm, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({nm, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({nm, "_resp_mis"}, {31'd0, resp_misaligned}, 32'd0);
    chk({nm, "_we"}, {31'd0, cache_d_write_en}, 32'd0);
    chk({nm, "_wkind"}, {30'd0, cache_d_write}, {30'd0, SW});
    chk({nm, "_addr"}, cache_addr, 32'd0);
    chk({nm, "_wdata"}, cache_data_to_cache, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("init");
    rst = 1'b0;

    issue("sw10",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 3, 1, SW, 32'hDEADBEEF);
    issue("lw10",  0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0, 3, 0, SW, 0);
    issue("sw10b", 1, 2'b10, 0, 32'h10, 32'h80FF7F01, 0, 0, 3, 1, SW, 32'h80FF7F01);
    issue("lb13",  0, 2'b00, 0, 32'h13, 0, 32'hFFFFFF80, 0, 3, 0, SW, 0);
    issue("lbu13", 0, 2'b00, 1, 32'h13, 0, 32'h00000080, 0, 3, 0, SW, 0);
    issue("lb12",  0, 2'b00, 0, 32'h12, 0, 32'hFFFFFFFF, 0, 3, 0, SW, 0);
    issue("lb11",  0, 2'b00, 0, 32'h11, 0, 32'h0000007F, 0, 3, 0, SW, 0);
    issue("lh10",  0, 2'b01, 0, 32'h10, 0, 32'h00007F01, 0, 3, 0, SW, 0);
    issue("lhu12", 0, 2'b01, 1, 32'h12, 0, 32'h000080FF, 0, 3, 0, SW, 0);
    issue("lh12",  0, 2'b01, 0, 32'h12, 0, 32'hFFFF80FF, 0, 3, 0, SW, 0);

    issue("sw20",  1, 2'b10, 0, 32'h20, 32'h11223344, 0, 0, 3, 1, SW, 32'h11223344);
    issue("sb22",  1, 2'b00, 0, 32'h22, 32'h000000AA, 0, 0, 5, 1, SW, 32'h11AA3344);
    issue("lw20",  0, 2'b10, 0, 32'h20, 0, 32'h11AA3344, 0, 3, 0, SW, 0);
    issue("sb20",  1, 2'b00, 0, 32'h20, 32'h00000055, 0, 0, 3, 1, SB, 32'h00000055);
    issue("lw20b", 0, 2'b10, 0, 32'h20, 0, 32'h11AA3355, 0, 3, 0, SW, 0);

    issue("sw24",  1, 2'b10, 0, 32'h24, 32'hFFFFFFFF, 0, 0, 3, 1, SW, 32'hFFFFFFFF);
    issue("sh24",  1, 2'b01, 0, 32'h24, 32'h0000BEEF, 0, 0, 3, 1, SH, 32'h0000BEEF);
    issue("lw24",  0, 2'b10, 0, 32'h24, 0, 32'hFFFFBEEF, 0, 3, 0, SW, 0);
    issue("sh26",  1, 2'b01, 0, 32'h26, 32'h00001234, 0, 0, 5, 1, SW, 32'h1234BEEF);
    issue("lw24b", 0, 2'b10, 0, 32'h24, 0, 32'h1234BEEF, 0, 3, 0, SW, 0);

    issue("lw31",  0, 2'b10, 0, 32'h31, 0, 0, 1, 1, 0, SW, 0);
    issue("sh33",  1, 2'b01, 0, 32'h33, 32'h0000ABCD, 0, 1, 1, 0, SW, 0);
    issue("sz11",  1, 2'b11, 0, 32'h30, 32'h12345678, 0, 1, 1, 0, SW, 0);
    issue("lw30",  0, 2'b10, 0, 32'h30, 0, 32'h00000000, 0, 3, 0, SW, 0);

    // Abort an RMW byte store in its read-data cycle.
    @(negedge clk);
    req_is_store = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h21;
    req_wdata    = 32'h000000CC;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("abort");
    rst = 1'b0;
    issue("lw20c", 0, 2'b10, 0, 32'h20, 0, 32'h11AA3355, 0, 3, 0, SW, 0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
